// File: rtl/systolic_pkg.sv
// Shared defaults and control state encoding for the systolic matrix-multiply datapath.
package systolic_pkg;
  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMPUTE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/systolic_pe.sv
// Signed MAC cell: acc += a*b per enabled cycle, a/b forwarded right/down one cycle later.
// Clear and reset zero both the accumulator and the pass-through registers.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);
  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] prod;

  assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){a_in[DATA_WIDTH-1]}}, a_in};
  assign b_ext = {{(ACC_WIDTH-DATA_WIDTH){b_in[DATA_WIDTH-1]}}, b_in};
  // Truncated product keeps the low ACC_WIDTH bits, so sums wrap modulo 2^ACC_WIDTH.
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= acc + prod;
      a_out <= a_in;
      b_out <= b_in;
    end
  end
endmodule

// File: rtl/systolic_array_top.sv
// Output-stationary NxN systolic multiplier C = A x B; done pulses 3N+1 cycles after start.
// Host writes/starts are dropped while busy; reads of C are always allowed with 1-cycle latency.
module systolic_array_top
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_a,
  input  logic                         wr_en_b,
  input  logic [ADDR_WIDTH-1:0]        wr_row_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data [ARRAY_SIZE],
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic [ADDR_WIDTH-1:0]        rd_row_addr,
  output logic signed [ACC_WIDTH-1:0]  rd_data [ARRAY_SIZE]
);
  localparam int N     = ARRAY_SIZE;
  localparam int CNT_W = $clog2(3 * N);
  localparam int LAST  = 3 * N - 2;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic                        pe_clr;
  logic                        pe_en;

  logic signed [DATA_WIDTH-1:0] a_mem  [N][N];
  logic signed [DATA_WIDTH-1:0] b_mem  [N][N];
  logic signed [ACC_WIDTH-1:0]  c_mem  [N][N];
  logic signed [DATA_WIDTH-1:0] a_nxt  [N];
  logic signed [DATA_WIDTH-1:0] b_nxt  [N];
  logic signed [DATA_WIDTH-1:0] a_feed [N];
  logic signed [DATA_WIDTH-1:0] b_feed [N];
  logic signed [DATA_WIDTH-1:0] a_h    [N][N+1];
  logic signed [DATA_WIDTH-1:0] b_v    [N+1][N];
  logic signed [ACC_WIDTH-1:0]  acc_w  [N][N];

  assign pe_clr = (state == ST_CLEAR);
  assign pe_en  = (state == ST_COMPUTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_COMPUTE;
          cnt   <= '0;
        end
        ST_COMPUTE: begin
          if (cnt == CNT_W'(LAST)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      end
    end else if (!busy) begin
      for (int j = 0; j < N; j++) begin
        if (wr_en_a) a_mem[wr_row_addr][j] <= wr_data[j];
        if (wr_en_b) b_mem[wr_row_addr][j] <= wr_data[j];
      end
    end
  end

  // Row i of A / column i of B is skewed by i cycles; k = cnt - i, zero outside 0..N-1.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      if ((cnt >= CNT_W'(i)) && (cnt < CNT_W'(i + N))) begin
        a_nxt[i] = a_mem[i][ADDR_WIDTH'(cnt - CNT_W'(i))];
        b_nxt[i] = b_mem[ADDR_WIDTH'(cnt - CNT_W'(i))][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pe_clr) begin
      for (int i = 0; i < N; i++) begin
        a_feed[i] <= '0;
        b_feed[i] <= '0;
      end
    end else if (pe_en) begin
      for (int i = 0; i < N; i++) begin
        a_feed[i] <= a_nxt[i];
        b_feed[i] <= b_nxt[i];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign a_h[gi][0] = a_feed[gi];
    assign b_v[0][gi] = b_feed[gi];
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (pe_clr),
        .en    (pe_en),
        .a_in  (a_h[gi][gj]),
        .b_in  (b_v[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .b_out (b_v[gi+1][gj]),
        .acc   (acc_w[gi][gj])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        rd_data[i] <= '0;
        for (int j = 0; j < N; j++) c_mem[i][j] <= '0;
      end
    end else begin
      if (state == ST_DONE) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) c_mem[i][j] <= acc_w[i][j];
        end
      end
      for (int j = 0; j < N; j++) rd_data[j] <= c_mem[rd_row_addr][j];
    end
  end
endmodule

// File: tb/tb_systolic_array_top.sv
// Randomized bench for systolic_array_top against a plain triple-loop matrix product.
module tb_systolic_array_top;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en_a;
  logic              wr_en_b;
  logic [2:0]        wr_row_addr;
  logic signed [7:0] wr_data [N];
  logic              start;
  logic              busy;
  logic              done;
  logic [2:0]        rd_row_addr;
  logic signed [31:0] rd_data [N];

  int ma [N][N];
  int mb [N][N];
  int mc [N][N];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_array_top dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_a     (wr_en_a),
    .wr_en_b     (wr_en_b),
    .wr_row_addr (wr_row_addr),
    .wr_data     (wr_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_row_addr (rd_row_addr),
    .rd_data     (rd_data)
  );

  function automatic void golden();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        mc[i][j] = s;
      end
    end
  endfunction

  task automatic load_ab();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      wr_en_a = 1'b1; wr_en_b = 1'b0; wr_row_addr = 3'(i);
      for (int j = 0; j < N; j++) wr_data[j] = 8'(ma[i][j]);
      @(negedge clk);
      wr_en_a = 1'b0; wr_en_b = 1'b1;
      for (int j = 0; j < N; j++) wr_data[j] = 8'(mb[i][j]);
    end
    @(negedge clk);
    wr_en_a = 1'b0; wr_en_b = 1'b0;
    golden();
  endtask

  task automatic do_run(input string name, input bit disturb);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start got %0b expected 1", name, busy);
    end
    while (done !== 1'b1 && n < 200) begin
      if (disturb && n == 6) begin
        start = 1'b1; wr_en_a = 1'b1; wr_en_b = 1'b1; wr_row_addr = 3'd7;
        for (int j = 0; j < N; j++) wr_data[j] = 8'($urandom);
      end else if (disturb && n == 7) begin
        start = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n !== 3 * N + 1) begin
      n_fail++; $display("FAIL %s done_latency got %0d expected %0d", name, n, 3 * N + 1);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_in_done got %0b expected 0", name, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL %s done_width got %0b expected 0", name, done);
    end
  endtask

  task automatic check_c(input string name);
    for (int r = 0; r < N; r++) begin
      rd_row_addr = 3'(r);
      @(negedge clk);
      for (int j = 0; j < N; j++) begin
        n_cmp++;
        if (rd_data[j] !== mc[r][j]) begin
          n_fail++;
          $display("FAIL %s C[%0d][%0d] got %0d expected %0d", name, r, j, rd_data[j], mc[r][j]);
        end
      end
    end
  endtask

  task automatic check_elem(input string name, input int r, input int c, input int exp);
    rd_row_addr = 3'(r);
    @(negedge clk);
    n_cmp++;
    if (rd_data[c] !== exp) begin
      n_fail++; $display("FAIL %s C[%0d][%0d] got %0d expected %0d", name, r, c, rd_data[c], exp);
    end
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = lo + int'($urandom_range(hi - lo, 0));
        mb[i][j] = lo + int'($urandom_range(hi - lo, 0));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset busy/done got %0b/%0b expected 0/0", busy, done);
    end
    for (int j = 0; j < N; j++) begin
      n_cmp++;
      if (rd_data[j] !== 32'sd0) begin
        n_fail++; $display("FAIL reset rd_data[%0d] got %0d expected 0", j, rd_data[j]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mc[i][j] = 0;
    check_c("reset_c");
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (8 * i + j + 1) % 120;
        mb[i][j] = (i == j) ? 1 : 0;
      end
    end
    load_ab();
    do_run("identity", 1'b0);
    check_c("identity");
    check_elem("identity_corner", 7, 7, 64);
  endtask

  task automatic test_known_values();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i + j + 1) % 10;
        mb[i][j] = (2 * i + j) % 8;
      end
    end
    load_ab();
    do_run("known", 1'b0);
    check_c("known");
    check_elem("known_c00", 0, 0, 128);
  endtask

  task automatic test_back_to_back();
    fill_random(0, 15);
    load_ab();
    do_run("b2b_first", 1'b0);
    check_c("b2b_first");
    fill_random(1, 10);
    load_ab();
    do_run("b2b_second", 1'b0);
    do_run("b2b_throughput", 1'b0);
    check_c("b2b_second");
  endtask

  task automatic test_signed();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = -15;
        mb[i][j] = 15;
      end
    end
    load_ab();
    do_run("signed_const", 1'b0);
    check_c("signed_const");
    check_elem("signed_const_c34", 3, 4, -1800);
    fill_random(-15, 15);
    load_ab();
    do_run("signed_rand", 1'b0);
    check_c("signed_rand");
  endtask

  task automatic test_ignore_while_busy();
    fill_random(-15, 15);
    load_ab();
    do_run("busy_ignore", 1'b1);
    check_c("busy_ignore");
  endtask

  task automatic test_reset_mid();
    fill_random(0, 15);
    load_ab();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid busy/done got %0b/%0b expected 0/0", busy, done);
    end
    for (int j = 0; j < N; j++) begin
      n_cmp++;
      if (rd_data[j] !== 32'sd0) begin
        n_fail++; $display("FAIL reset_mid rd_data[%0d] got %0d expected 0", j, rd_data[j]);
      end
    end
    fill_random(-15, 15);
    load_ab();
    do_run("after_reset", 1'b0);
    check_c("after_reset");
  endtask

  initial begin
    rst = 1'b1; wr_en_a = 1'b0; wr_en_b = 1'b0; wr_row_addr = '0;
    start = 1'b0; rd_row_addr = '0;
    for (int j = 0; j < N; j++) wr_data[j] = '0;
    test_reset();
    test_identity();
    test_known_values();
    test_back_to_back();
    test_signed();
    test_ignore_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
